// File: rtl/msg_validator_seq.sv
// Sequential plaintext checker behind the RC4 core: captures a 32-byte message on start and
// scans one byte per clock for lowercase/space. Define VALIDATOR_UPPER_EN to also accept 'A'-'Z'.
module msg_validator_seq #(
   parameter logic [7:0] LOW_THRESHOLD  = 8'd97,
   parameter logic [7:0] HIGH_THRESHOLD = 8'd122,
   parameter logic [7:0] SPECIAL        = 8'd32,
   parameter logic [4:0] END_INDEX      = 5'd31
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] decrypted_data [31:0],
   output logic       busy,
   output logic       finish,
   output logic       key_valid,
   output logic [4:0] bad_index,
   output logic [7:0] bad_byte,
   output logic [5:0] checked_count,
   output logic [1:0] state_dbg
);

   // Handshake: start is a request honoured only in IDLE or DONE; finish is a level that
   // acts as the result-valid flag and stays high until the next accepted start or reset.
   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

   state_t     state, state_n;
   logic [7:0] msg [31:0];
   logic [4:0] idx, idx_n;
   logic [5:0] count_n;
   logic [4:0] bad_index_n;
   logic [7:0] bad_byte_n;
   logic       busy_n, finish_n, key_valid_n;
   logic       load;
   logic [7:0] cur_byte;

   function automatic logic is_legal(input logic [7:0] b);
      logic ok;
      ok = ((b >= LOW_THRESHOLD) && (b <= HIGH_THRESHOLD)) || (b == SPECIAL);
`ifdef VALIDATOR_UPPER_EN
      ok = ok || ((b >= 8'd65) && (b <= 8'd90));
`endif
      return ok;
   endfunction

   assign cur_byte  = msg[idx];
   assign state_dbg = state;

   always_comb begin
      state_n     = state;
      idx_n       = idx;
      count_n     = checked_count;
      bad_index_n = bad_index;
      bad_byte_n  = bad_byte;
      busy_n      = busy;
      finish_n    = finish;
      key_valid_n = key_valid;
      load        = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               load        = 1'b1;
               idx_n       = 5'd0;
               count_n     = 6'd0;
               finish_n    = 1'b0;
               key_valid_n = 1'b0;
               busy_n      = 1'b1;
               state_n     = SCAN;
            end
         end
         SCAN: begin
            count_n = checked_count + 6'd1;
            if (!is_legal(cur_byte)) begin
               bad_index_n = idx;
               bad_byte_n  = cur_byte;
               key_valid_n = 1'b0;
               finish_n    = 1'b1;
               busy_n      = 1'b0;
               state_n     = DONE;
            end else if (idx == END_INDEX) begin
               bad_index_n = 5'd0;
               bad_byte_n  = 8'd0;
               key_valid_n = 1'b1;
               finish_n    = 1'b1;
               busy_n      = 1'b0;
               state_n     = DONE;
            end else begin
               idx_n = idx + 5'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state         <= IDLE;
         idx           <= 5'd0;
         checked_count <= 6'd0;
         bad_index     <= 5'd0;
         bad_byte      <= 8'd0;
         busy          <= 1'b0;
         finish        <= 1'b0;
         key_valid     <= 1'b0;
      end else begin
         state         <= state_n;
         idx           <= idx_n;
         checked_count <= count_n;
         bad_index     <= bad_index_n;
         bad_byte      <= bad_byte_n;
         busy          <= busy_n;
         finish        <= finish_n;
         key_valid     <= key_valid_n;
      end
   end

   // The message copy needs no reset: it is only read after a start has loaded it.
   always_ff @(posedge CLOCK_50) begin
      if (load && !reset) msg <= decrypted_data;
   end

endmodule
